// File: rtl/slot_allocator_pkg.sv
// Shared definitions for slot allocator producers and consumers.
// Holds the default slot count and the slot-id type sized to match it.
package slot_allocator_pkg;

  localparam int DEPTH_DEFAULT = 16;
  localparam int SLOT_ID_W     = $clog2(DEPTH_DEFAULT);

  typedef logic [SLOT_ID_W-1:0] slot_id_t;

endpackage

// File: rtl/slot_allocator_if.sv
// Allocate/free/flush request bundle and status returned by the allocator.
// master = client side driving requests, slave = allocator side.
interface slot_allocator_if #(
  parameter int DEPTH = slot_allocator_pkg::DEPTH_DEFAULT
);

  localparam int IDW  = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic            alloc_req;
  logic            alloc_ready;
  logic [IDW-1:0]  alloc_id;
  logic            free_valid;
  logic [IDW-1:0]  free_id;
  logic            flush;
  logic [CNTW-1:0] free_count;
  logic            double_free;

  modport master (
    output alloc_req, free_valid, free_id, flush,
    input  alloc_ready, alloc_id, free_count, double_free
  );

  modport slave (
    input  alloc_req, free_valid, free_id, flush,
    output alloc_ready, alloc_id, free_count, double_free
  );

endinterface

// File: rtl/parallel_finder.sv
// Lowest-set-bit finder: index is the lowest set bit of vec, index_valid is any bit set.
// Purely combinational; index is 0 when no bit is set.
module parallel_finder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     index_valid
);

  localparam int IW = $clog2(WIDTH);

  always_comb begin
    index = '0;
    // Scan from the top so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) index = IW'(i);
    end
  end

  assign index_valid = |vec;

endmodule

// File: rtl/slot_allocator.sv
// Slot allocator: busy bitmap with zero-latency lowest-free grant, free, flush and free count.
// Optional sticky double-free detection is enabled by `define SLOT_ALLOCATOR_DOUBLE_FREE_CHECK_EN.
import slot_allocator_pkg::*;

module slot_allocator #(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  slot_allocator_if.slave    bus
);

  localparam int IDW  = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNTW-1:0]  free_count_q, free_count_d;
  logic [IDW-1:0]   lowest_free;
  logic             any_free;
  logic             alloc_fire;
  logic             free_fire;

  parallel_finder #(.WIDTH(DEPTH)) u_finder (
    .vec         (~busy_q),
    .index       (lowest_free),
    .index_valid (any_free)
  );

  assign bus.alloc_ready = any_free;
  assign bus.alloc_id    = any_free ? lowest_free : '0;
  assign bus.free_count  = free_count_q;

  assign alloc_fire = bus.alloc_req & any_free;
  // A granted slot is free and a fired free targets a busy slot, so they never collide.
  assign free_fire  = bus.free_valid & busy_q[bus.free_id];

  always_comb begin
    busy_d       = busy_q;
    free_count_d = free_count_q;
    if (bus.flush) begin
      busy_d       = '0;
      free_count_d = CNTW'(DEPTH);
    end else begin
      if (alloc_fire) busy_d[lowest_free] = 1'b1;
      if (free_fire)  busy_d[bus.free_id] = 1'b0;
      case ({alloc_fire, free_fire})
        2'b10:   free_count_d = free_count_q - CNTW'(1);
        2'b01:   free_count_d = free_count_q + CNTW'(1);
        default: free_count_d = free_count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      free_count_q <= CNTW'(DEPTH);
    end else begin
      busy_q       <= busy_d;
      free_count_q <= free_count_d;
    end
  end

`ifdef SLOT_ALLOCATOR_DOUBLE_FREE_CHECK_EN
  logic double_free_q, double_free_d;

  always_comb begin
    double_free_d = double_free_q;
    if (bus.free_valid && !busy_q[bus.free_id] && !bus.flush) double_free_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) double_free_q <= 1'b0;
    else     double_free_q <= double_free_d;
  end

  assign bus.double_free = double_free_q;
`else
  assign bus.double_free = 1'b0;
`endif

endmodule

// File: doc/slot_allocator.md
SLOT_ALLOCATOR -- requirements
Module: slot_allocator

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of allocatable slots; it is a power of two and at least 2.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 alloc_req  input  1  SHALL request one slot this cycle.
REQ-005 alloc_ready  output  1  SHALL be high when at least one slot is free.
REQ-006 alloc_id  output  $clog2(DEPTH)  SHALL give the slot granted when alloc_req and alloc_ready are both high.
REQ-007 free_valid  input  1  SHALL request release of one slot.
REQ-008 free_id  input  $clog2(DEPTH)  SHALL identify the slot to release.
REQ-009 flush  input  1  SHALL release all slots.
REQ-010 free_count  output  $clog2(DEPTH)+1  SHALL give the number of free slots.
REQ-011 double_free  output  1  SHALL be a sticky error flag (see Configuration).

Function
REQ-012 State SHALL be a DEPTH-bit busy bitmap plus a registered free_count; no other state beyond the double_free flag.
REQ-013 alloc_id and alloc_ready SHALL be combinational from the registered bitmap: alloc_id is the lowest-index free slot and alloc_ready is any-free.
REQ-014 On a cycle where alloc_req and alloc_ready are both high, slot alloc_id SHALL be busy from the next cycle; alloc_req with alloc_ready low SHALL be ignored.
REQ-015 On a cycle where free_valid is high and slot free_id is busy, that slot SHALL be free from the next cycle.
REQ-016 A free of an already-free slot SHALL leave the bitmap and free_count unchanged.
REQ-017 For a simultaneous alloc and free in the same cycle, both SHALL take effect and free_count SHALL be unchanged.
REQ-018 A slot freed in cycle N SHALL NOT be grantable before cycle N+1; there is no free-to-alloc bypass.
REQ-019 flush SHALL override alloc and free in the same cycle: next cycle all slots are free and free_count is DEPTH; no grant is counted in the flush cycle.
REQ-020 free_count SHALL always equal the number of zero bits in the bitmap, updated by +1, -1 or 0 per cycle, never wrapping.
REQ-021 When full, alloc_ready SHALL be low and alloc_id SHALL be 0.
REQ-022 Grant latency SHALL be zero cycles: the grant is visible in the request cycle and committed at the next edge.

Reset
REQ-023 While rst is high, all slots SHALL become free at the next edge, overriding flush, alloc and free.
REQ-024 After reset, the outputs SHALL be: alloc_ready=1, alloc_id=0, free_count=DEPTH, double_free=0.
REQ-025 A reset asserted mid-operation SHALL discard all outstanding allocations, with no partial update.

Configuration
REQ-026 Macro SLOT_ALLOCATOR_DOUBLE_FREE_CHECK_EN SHALL control the double-free check.
- When defined: free_valid on a free slot without flush sets double_free=1, held until reset.
- When undefined: double_free is tied to 0 and no check logic exists.
- REQ-016 behaviour is identical in both cases.

Structure
REQ-027 The shared package SHALL hold the DEPTH default and the slot-id typedef, sized $clog2(DEPTH), for use by producers and consumers.
REQ-028 Lowest-free selection SHALL instantiate the existing parallel_finder (WIDTH=DEPTH) on the inverted bitmap.
- parallel_finder outputs: index = lowest set bit, index_valid = any set.
- No other sub-module.

Verification (DEPTH=4)
REQ-029 Reset, then 4 consecutive alloc_req cycles: alloc_id SHALL be 0,1,2,3; free_count SHALL be 3,2,1,0; alloc_ready SHALL be 0 after the fourth grant.
REQ-030 Full, then free_id=2: the next cycle SHALL show alloc_ready=1, alloc_id=2, free_count=1.
REQ-031 Slots 0,1 busy, then alloc_req plus free_id=0 in the same cycle: the grant SHALL be id 2, then the next cycle SHALL show alloc_id=0 and free_count=2.
REQ-032 Full, then flush with alloc_req and free_valid in the same cycle: the next cycle SHALL show free_count=4, alloc_id=0, with no double_free.
REQ-033 After reset, free_id=1 with slot 1 free: free_count SHALL stay 4; double_free SHALL be 1 with the macro defined and 0 with it undefined.
REQ-034 Reset asserted while 3 slots are busy: the next cycle SHALL show free_count=4, alloc_ready=1, double_free=0.
